// File: rtl/vga_timing_core.sv
// vga_timing_core
// Parametrised raster timing generator. A clock-enable divider produces one
// pixel tick every CLK_DIV clk cycles; horizontal/vertical counters advance on
// each tick, and all outputs are registered from the pre-advance counter decode.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset (priority over en)
//   en          run enable; 0 freezes divider, counters and outputs
//   hsync       horizontal sync, asserted level HSYNC_POL
//   vsync       vertical sync, asserted level VSYNC_POL
//   col, row    current pixel coordinates
//   visible     pixel lies inside the active area
//   pix_en      one-clk strobe on the first cycle of each new pixel
//   line_start  pix_en at col 0
//   frame_start pix_en at col 0, row 0
module vga_timing_core #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   CNT_W     = 10,
    parameter int   CLK_DIV   = 1,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             visible,
    output logic             pix_en,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Boundaries pre-sized to the counter width so compares are width-exact.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             tick;
    logic             hs_act;
    logic             vs_act;
    logic             in_vis;

    // Decode of the current (pre-advance) position, registered on tick.
    always_comb begin
        tick   = en && (div == DIV_LAST);
        hs_act = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_act = (vcnt >= VS_BEG) && (vcnt < VS_END);
        in_vis = (hcnt < H_VIS) && (vcnt < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            col         <= '0;
            row         <= '0;
            visible     <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes last exactly one clk; they drop on the next cycle.
            pix_en      <= tick;
            line_start  <= tick && (hcnt == '0);
            frame_start <= tick && (hcnt == '0) && (vcnt == '0);

            if (en)
                div <= tick ? '0 : div + 1'b1;

            if (tick) begin
                col     <= hcnt;
                row     <= vcnt;
                visible <= in_vis;
                hsync   <= hs_act ? HSYNC_POL : ~HSYNC_POL;
                vsync   <= vs_act ? VSYNC_POL : ~VSYNC_POL;

                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: four configurations share clk/rst_n/en.
// Reference model: position derived arithmetically from the number of enabled
// cycles since reset (ticks = n / CLK_DIV, pixel = (ticks-1) mod frame size).
module tb_vga_timing_core;

    typedef struct {
        int hv, hfp, hsw, hbp;
        int vv, vfp, vsw, vbp;
        int d;
        bit hp, vp;
    } cfg_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       hs  [4];
    logic       vs  [4];
    logic       vis [4];
    logic       pe  [4];
    logic       ls  [4];
    logic       fs  [4];
    logic [9:0] col [4];
    logic [9:0] row [4];

    cfg_t   cfg [4];
    longint n   [4];
    bit     tk  [4];
    int     checks, errors, cyc;
    bit     disturbed;
    int     fs_cyc1, fs_cyc3, vis_cnt3, hlow, hbad;
    bit     fs_ok1, fs_ok3, ln_ok;

    // 0: default 640x480, div 1
    vga_timing_core u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[0]), .vsync(vs[0]),
        .col(col[0]), .row(row[0]), .visible(vis[0]), .pix_en(pe[0]),
        .line_start(ls[0]), .frame_start(fs[0]));

    // 1: small mode, div 3, active-high syncs
    vga_timing_core #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CNT_W(10), .CLK_DIV(3), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[1]), .vsync(vs[1]),
        .col(col[1]), .row(row[1]), .visible(vis[1]), .pix_en(pe[1]),
        .line_start(ls[1]), .frame_start(fs[1]));

    // 2: medium mode, div 2, mixed polarity
    vga_timing_core #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .CNT_W(10), .CLK_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) u_med2 (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[2]), .vsync(vs[2]),
        .col(col[2]), .row(row[2]), .visible(vis[2]), .pix_en(pe[2]),
        .line_start(ls[2]), .frame_start(fs[2]));

    // 3: medium mode, div 1, opposite polarity
    vga_timing_core #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .CNT_W(10), .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_med1 (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hs[3]), .vsync(vs[3]),
        .col(col[3]), .row(row[3]), .visible(vis[3]), .pix_en(pe[3]),
        .line_start(ls[3]), .frame_start(fs[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [25:0] obs(input int k);
        return {hs[k], vs[k], vis[k], pe[k], ls[k], fs[k], col[k], row[k]};
    endfunction

    // Expected output vector from enabled-cycle count and last-edge tick flag.
    function automatic logic [25:0] model(input cfg_t c, input longint cnt, input bit t);
        longint ticks, p;
        int     ht, vt, cx, ry;
        bit     hsv, vsv, vi;
        ticks = cnt / c.d;
        if (ticks == 0)
            return {~c.hp, ~c.vp, 4'b0000, 10'd0, 10'd0};
        ht  = c.hv + c.hfp + c.hsw + c.hbp;
        vt  = c.vv + c.vfp + c.vsw + c.vbp;
        p   = (ticks - 1) % (ht * vt);
        cx  = int'(p % ht);
        ry  = int'(p / ht);
        vi  = (cx < c.hv) && (ry < c.vv);
        hsv = (cx >= c.hv + c.hfp && cx < c.hv + c.hfp + c.hsw) ? c.hp : ~c.hp;
        vsv = (ry >= c.vv + c.vfp && ry < c.vv + c.vfp + c.vsw) ? c.vp : ~c.vp;
        return {hsv, vsv, vi, t, t && cx == 0, t && p == 0, 10'(cx), 10'(ry)};
    endfunction

    // One clk: update model at the edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                n[k]  = 0;
                tk[k] = 1'b0;
            end else if (en) begin
                n[k]  = n[k] + 1;
                tk[k] = (n[k] % cfg[k].d) == 0;
            end else begin
                tk[k] = 1'b0;
            end
        end
        disturbed = !rst_n || !en;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++)
            chk($sformatf("inst%0d_outputs", k), 32'(obs(k)), 32'(model(cfg[k], n[k], tk[k])));

        if (disturbed) begin
            fs_ok1 = 1'b0;
            fs_ok3 = 1'b0;
            ln_ok  = 1'b0;
        end
        if (fs[1]) begin
            if (fs_ok1) chk("frame_period_small", cyc - fs_cyc1, 144);
            fs_cyc1 = cyc;
            fs_ok1  = 1'b1;
        end
        if (fs[3]) begin
            if (fs_ok3) begin
                chk("frame_period_med", cyc - fs_cyc3, 672);
                chk("visible_count_med", vis_cnt3, 240);
            end
            fs_cyc3  = cyc;
            fs_ok3   = 1'b1;
            vis_cnt3 = 0;
        end
        if (pe[3] && vis[3]) vis_cnt3++;
        if (ls[0]) begin
            if (ln_ok) begin
                chk("hsync_low_per_line", hlow, 96);
                chk("hsync_low_outside_656_751", hbad, 0);
            end
            hlow  = 0;
            hbad  = 0;
            ln_ok = 1'b1;
        end
        if (!hs[0]) begin
            hlow++;
            if (col[0] < 656 || col[0] > 751) hbad++;
        end
    endtask

    initial begin
        bit found;
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
        cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 3, 1'b1, 1'b1};
        cfg[2] = '{20, 3, 4, 5, 12, 2, 3, 4, 2, 1'b0, 1'b1};
        cfg[3] = '{20, 3, 4, 5, 12, 2, 3, 4, 1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            n[k]  = 0;
            tk[k] = 1'b0;
        end
        checks = 0; errors = 0; cyc = 0;
        fs_ok1 = 0; fs_ok3 = 0; ln_ok = 0;
        fs_cyc1 = 0; fs_cyc3 = 0; vis_cnt3 = 0; hlow = 0; hbad = 0;
        rst_n = 1'b0;
        en    = 1'b1;

        // Reset held with en=1
        for (int i = 0; i < 5; i++) cycle();
        chk("reset_default", 32'(obs(0)), 32'h300_0000);
        chk("reset_small", 32'(obs(1)), 32'h000_0000);

        // First pixel one clk after release (div 1)
        rst_n = 1'b1;
        cycle();
        chk("first_pixel_default", 32'(obs(0)), 32'h3F0_0000);

        // Free run: several default lines, many small/medium frames
        for (int i = 0; i < 2500; i++) cycle();

        // Freeze mid-line on the div-2 instance
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            if (pe[2] && col[2] == 10'd10) found = 1'b1;
        end
        chk("freeze_wait", 32'(found), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("freeze_col", 32'(col[2]), 32'd10);
            chk("freeze_pix_en", 32'(pe[2]), 32'd0);
        end
        en = 1'b1;
        cycle();
        chk("resume_wait_pix_en", 32'(pe[2]), 32'd0);
        cycle();
        chk("resume_next_col", 32'({pe[2], col[2]}), 32'h40B);

        // Reset mid-frame on the div-1 medium instance
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            if (row[3] == 10'd5 && col[3] == 10'd15) found = 1'b1;
        end
        chk("midreset_wait", 32'(found), 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("midreset_values_med", 32'(obs(3)), 32'h100_0000);
        chk("midreset_values_default", 32'(obs(0)), 32'h300_0000);
        rst_n = 1'b1;
        cycle();
        chk("midreset_restart", 32'(obs(3)), 32'h1F0_0000);

        // Last pixel of the frame wraps straight to (0,0)
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            cycle();
            if (pe[3] && col[3] == 10'd31 && row[3] == 10'd20) found = 1'b1;
        end
        chk("wrap_wait", 32'(found), 32'd1);
        cycle();
        chk("wrap_next", 32'({ls[3], fs[3], col[3], row[3]}), 32'h30_0000);

        // Random enable drops and occasional resets
        for (int i = 0; i < 20000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 2999) != 0);
            cycle();
        end
        en    = 1'b1;
        rst_n = 1'b1;

        // Steady run again so period/count measurements re-arm
        for (int i = 0; i < 3000; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
